// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the shared-multiplier controller.
// Optional statistics counters are enabled with MULT_SHARE_STATS_EN.
package mult_share_pkg;

    localparam int WIDTH  = 32;
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/classical.sv
// Combinational unsigned multiplier producing the full-width product.
// Shared by the requesters behind mult_share_ctrl.
module classical #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] ans
);

    assign ans = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the search starts at ptr.
// The pointer register lives in the parent controller.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin sharing of one multiplier with registered operands/product.
// Define MULT_SHARE_STATS_EN to add stat_ops / stat_stall counters.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = mult_share_pkg::WIDTH,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [2*WIDTH-1:0]       resp_ans
`ifdef MULT_SHARE_STATS_EN
    ,
    output logic [31:0]              stat_ops,
    output logic [31:0]              stat_stall
`endif
);

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    ptr_nxt;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [ID_W-1:0]    op_id;
    logic [2*WIDTH-1:0] ans_q;
    logic [ID_W-1:0]    id_q;
    logic [2*WIDTH-1:0] prod;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               arb_en;
    logic               grant;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    // A new grant is only possible when the output slot is free.
    assign arb_en = (state == IDLE) || (state == DONE && resp_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    classical #(
        .WIDTH (WIDTH)
    ) u_mul (
        .a   (op_a),
        .b   (op_b),
        .ans (prod)
    );

    assign grant      = |gnt;
    assign req_ready  = gnt;
    assign resp_valid = (state == DONE);
    assign resp_id    = id_q;
    assign resp_ans   = ans_q;
    assign ptr_nxt    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                       : gnt_idx + ID_W'(1);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant) state_nxt = CALC;
            end
            CALC: state_nxt = DONE;
            DONE: begin
                if (resp_ready) state_nxt = grant ? CALC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_id  <= '0;
            ans_q  <= '0;
            id_q   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_id  <= gnt_idx;
                rr_ptr <= ptr_nxt;
            end
            if (state == CALC) begin
                ans_q <= prod;
                id_q  <= op_id;
            end
        end
    end

`ifdef MULT_SHARE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (resp_valid && resp_ready && stat_ops != '1)
                stat_ops <= stat_ops + 32'd1;
            if (state == DONE && !resp_ready && stat_stall != '1)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl: directed vectors, queue-based checker.
// Statistics checks run when MULT_SHARE_STATS_EN is defined.
module tb_mult_share_ctrl;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [IW-1:0]  resp_id;
    logic [2*W-1:0] resp_ans;
`ifdef MULT_SHARE_STATS_EN
    logic [31:0]    stat_ops;
    logic [31:0]    stat_stall;
`endif

    int vectors = 0;
    int errors  = 0;
    logic [IW+2*W-1:0] exp_q[$];
    logic [IW+2*W-1:0] mon_e;
    logic [N-1:0]      g;

    mult_share_ctrl #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .ID_W    (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_ans   (resp_ans)
`ifdef MULT_SHARE_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic push(int id, logic [2*W-1:0] ans);
        exp_q.push_back({IW'(id), ans});
    endtask

    // Count negedges until resp_valid; bounded so a dead DUT cannot hang.
    task automatic wait_resp(string name, int lat);
        int n;
        n = 0;
        do begin
            smp();
            n++;
        end while (!resp_valid && n < 10);
        chk(name, 64'(n), 64'(lat));
    endtask

    // Hold requests until granted, for a bounded number of cycles.
    task automatic serve();
        smp();
        g = req_ready;
        for (int c = 0; c < 12 && req_valid != '0; c++) begin
            tick();
            req_valid &= ~g;
            smp();
            g = req_ready;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_extra: got id %0d ans %h expected none",
                         resp_id, resp_ans);
            end else begin
                mon_e = exp_q.pop_front();
                if ({resp_id, resp_ans} !== mon_e) begin
                    errors++;
                    $display("FAIL resp: got id %0d ans %h expected id %0d ans %h",
                             resp_id, resp_ans, mon_e[2*W +: IW], mon_e[2*W-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        smp();
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_id", 64'(resp_id), 64'd0);
        chk("rst_ans", resp_ans, 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);

        // Single request, latency
        tick();
        rst = 1'b0;
        set_op(0, 32'd123123123, 32'd121212121);
        push(0, 64'd14924014882973883);
        req_valid = 4'b0001;
        smp();
        chk("t1_gnt", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        wait_resp("t1_lat", 2);
        tick();

        // Max operands
        set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push(2, 64'hFFFF_FFFE_0000_0001);
        req_valid = 4'b0100;
        smp();
        chk("t2_gnt", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        wait_resp("t2_lat", 2);
        tick();

        // Round-robin after reset, one response every two cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_op(i, W'(i + 1), 32'd10);
            push(i, 64'((i + 1) * 10));
        end
        req_valid = 4'b1111;
        for (int t = 0; t <= 8; t++) begin
            smp();
            g = req_ready;
            chk($sformatf("t3_gnt%0d", t), 64'(req_ready),
                (t % 2 == 0 && t < 8) ? 64'(1 << (t / 2)) : 64'd0);
            chk($sformatf("t3_vld%0d", t), 64'(resp_valid),
                (t % 2 == 0 && t >= 2) ? 64'd1 : 64'd0);
            tick();
            req_valid &= ~g;
        end

        // Backpressure with a pending request
        resp_ready = 1'b0;
        set_op(0, 32'd7, 32'd6);
        push(0, 64'd42);
        req_valid = 4'b0001;
        smp();
        chk("t4_gnt0", 64'(req_ready), 64'b0001);
        tick();
        set_op(0, 32'hdead, 32'hbeef);
        set_op(1, 32'd5, 32'd9);
        push(1, 64'd45);
        req_valid = 4'b0010;
        smp();
        chk("t4_calc_rdy", 64'(req_ready), 64'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            smp();
            chk($sformatf("t4_vld%0d", k), 64'(resp_valid), 64'd1);
            chk($sformatf("t4_ans%0d", k), resp_ans, 64'd42);
            chk($sformatf("t4_id%0d", k), 64'(resp_id), 64'd0);
            chk($sformatf("t4_rdy%0d", k), 64'(req_ready), 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        smp();
        chk("t4_gnt1", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_resp("t4_lat", 2);
        tick();

        // Reset while in CALC drops the request and the pointer
        set_op(1, 32'd3, 32'd3);
        req_valid = 4'b0010;
        smp();
        chk("t5_gnt", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        smp();
        chk("t5_vld", 64'(resp_valid), 64'd0);
        chk("t5_ans", resp_ans, 64'd0);
        tick();
        set_op(0, 32'd11, 32'd13);
        set_op(2, 32'd4, 32'd5);
        push(0, 64'd143);
        push(2, 64'd20);
        req_valid = 4'b0101;
        smp();
        chk("t5_ptr", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0100;
        serve();
        repeat (6) tick();
        chk("t5_drain", 64'(exp_q.size()), 64'd0);

`ifdef MULT_SHARE_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        smp();
        chk("s_ops0", 64'(stat_ops), 64'd0);
        chk("s_stall0", 64'(stat_stall), 64'd0);
        tick();
        resp_ready = 1'b0;
        set_op(0, 32'd2, 32'd3);
        push(0, 64'd6);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        repeat (4) tick();
        resp_ready = 1'b1;
        tick();
        set_op(1, 32'd4, 32'd4);
        set_op(2, 32'd5, 32'd5);
        push(1, 64'd16);
        push(2, 64'd25);
        req_valid = 4'b0110;
        serve();
        repeat (4) tick();
        smp();
        chk("s_ops", 64'(stat_ops), 64'd3);
        chk("s_stall", 64'(stat_stall), 64'd4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        smp();
        chk("s_ops_rst", 64'(stat_ops), 64'd0);
        chk("s_stall_rst", 64'(stat_stall), 64'd0);
        chk("s_drain", 64'(exp_q.size()), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Shares one combinational 32x32 `classical` multiplier (ports a, b, ans) between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake on both the request and response sides.
- Registers operands and the product around the multiplier, giving a fixed 2-cycle latency.
- Sits between the multiplier datapath and any blocks needing occasional 64-bit products.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand width; product is 2*WIDTH
- ID_W, 2, requester-index width, equal to clog2(NUM_REQ)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing as req_a
- resp_valid  out  1  product available
- resp_ready  in  1  consumer accepts product
- resp_id  out  ID_W  index of the requester that owns the product
- resp_ans  out  2*WIDTH  unsigned product

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, rr_ptr=0.
  - resp_valid=0, resp_id=0, resp_ans=0, req_ready=0.
  - Operand registers cleared.
- Reset mid-operation: any in-flight product is discarded; the next cycle is IDLE with no response.
- States: IDLE, CALC, DONE.
- IDLE:
  - If any req_valid is set, the arbiter picks winner g and req_ready[g]=1 combinationally.
  - At the clock edge: op_a, op_b and op_id latch req_a[g], req_b[g] and g; state goes to CALC.
  - If no request is valid, stay in IDLE.
- CALC:
  - The multiplier sees op_a and op_b.
  - At the edge: ans_q<=product, id_q<=op_id, state goes to DONE.
  - req_ready=0 throughout.
- DONE:
  - resp_valid=1; resp_ans and resp_id are driven from registers and are stable while resp_ready=0.
  - resp_ready=1 with any req_valid: grant the next winner in the same cycle (req_ready asserted), latch its operands, go to CALC.
  - resp_ready=1 with no request: go to IDLE.
  - resp_ready=0: remain in DONE; req_ready=0.
- Latency: accept edge to resp_valid = 2 cycles. Sustained throughput = 1 product per 2 cycles.
- Arbitration:
  - Round-robin starting from rr_ptr.
  - After a grant to g, rr_ptr = (g+1) mod NUM_REQ.
  - rr_ptr does not change when there is no grant.
  - After reset, requester 0 has highest priority.
- Operands are captured only at the handshake; requesters may change them afterwards.
- Requester rules:
  - A requester holds req_valid until it sees its req_ready.
  - Deasserting req_valid before the handshake is legal; that request is simply not granted.
- Arithmetic: unsigned; full 2*WIDTH product, no truncation.
  - 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001.

Optional Feature:
- Macro: MULT_SHARE_STATS_EN.
- Defined: adds outputs stat_ops (32-bit) and stat_stall (32-bit).
  - stat_ops increments on each response handshake.
  - stat_stall increments on each cycle in DONE with resp_ready=0.
  - Both counters saturate at 0xFFFFFFFF and clear on rst.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- Package mult_share_pkg:
  - state enum (IDLE, CALC, DONE).
  - Default widths WIDTH and PROD_W=2*WIDTH.
  - clog2 helper for ID_W.
- Sub-module rr_arbiter (NUM_REQ): inputs req, ptr and en; outputs gnt (one-hot) and gnt_idx. It is purely combinational; rr_ptr lives in mult_share_ctrl.
- The existing `classical` multiplier is instantiated unchanged.

Test Plan:
- Single request: req 0 with a=123123123, b=121212121 → resp_valid 2 cycles after accept; resp_ans=14924014882973883; resp_id=0.
- Max operands: req 2 with a=b=0xFFFFFFFF → resp_ans=0xFFFFFFFE00000001; resp_id=2.
- Round-robin: all 4 valid after reset with resp_ready=1 and a=i+1, b=10 → resp_id order 0,1,2,3; answers 10,20,30,40; one response every 2 cycles.
- Backpressure: resp_ready=0 for 5 cycles in DONE → resp_valid, resp_ans and resp_id stay stable; req_ready=0; request 1 stays pending and is granted on the cycle resp_ready rises.
- Reset mid-op: rst pulsed while in CALC → next cycle resp_valid=0, state IDLE, rr_ptr=0; the lost request is not answered.
- Stats (macro defined): 3 responses plus 4 stall cycles → stat_ops=3, stat_stall=4; rst → both 0.
